axi_lite_slave_adapter: RTL and testbench

- AXI4-Lite slave front end for the lane-detection core's simple memory-mapped bus.
- Converts the five AXI4-Lite channels into the core's single-cycle write strobe and latency-aware read port.
- Sits directly upstream of the core's top level. The processor writes image pixels and weights, reads the post-processed output, and polls the o_valid/busy registers and the soft-reset register through it.
- Read and write paths are independent and may be in flight simultaneously.

---
 rtl/axi_lite_slave_adapter.sv | 251 +++++++++++++++++++++++++
 tb/tb_axi_lite_slave_adapter.sv | 396 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_lite_slave_adapter.sv
// ---------------------------------------------------------------------------
// axi_lite_slave_adapter
//
// AXI4-Lite slave front end for the lane-detection core. It turns the five
// AXI4-Lite channels into the core's single-cycle write strobe and its
// latency-aware read port. The read and write paths are independent FSMs, so
// one read and one write may be in flight at the same time.
//
// Parameters
//   AXI_ADDR_WIDTH : byte address width. Addresses pass through unchanged.
//   RD_LATENCY     : clk cycles from axi_rd_en until axi_rd_data is valid
//                    (0..3).
//
// Ports
//   clk, rst_n                      clock, asynchronous active-low reset
//   s_aw*/s_w*/s_b*                 AXI4-Lite write address/data/response
//   s_ar*/s_r*                      AXI4-Lite read address/data
//   axi_wr_en/addr/data/strobe      single-cycle write strobe to the core
//   axi_rd_en/addr                  single-cycle read enable and held address
//   axi_rd_data                     core read data. It is combinational on
//                                   axi_rd_addr, with a registered RAM behind it.
// ---------------------------------------------------------------------------
module axi_lite_slave_adapter #(
    parameter int unsigned AXI_ADDR_WIDTH = 20,
    parameter int unsigned RD_LATENCY     = 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    // write address channel
    input  logic [AXI_ADDR_WIDTH-1:0] s_awaddr,
    input  logic                      s_awvalid,
    output logic                      s_awready,
    // write data channel
    input  logic [31:0]               s_wdata,
    input  logic [3:0]                s_wstrb,
    input  logic                      s_wvalid,
    output logic                      s_wready,
    // write response channel
    output logic [1:0]                s_bresp,
    output logic                      s_bvalid,
    input  logic                      s_bready,
    // read address channel
    input  logic [AXI_ADDR_WIDTH-1:0] s_araddr,
    input  logic                      s_arvalid,
    output logic                      s_arready,
    // read data channel
    output logic [31:0]               s_rdata,
    output logic [1:0]                s_rresp,
    output logic                      s_rvalid,
    input  logic                      s_rready,
    // core side
    output logic                      axi_wr_en,
    output logic [AXI_ADDR_WIDTH-1:0] axi_wr_addr,
    output logic [31:0]               axi_wr_data,
    output logic [3:0]                axi_wr_strobe,
    output logic                      axi_rd_en,
    output logic [AXI_ADDR_WIDTH-1:0] axi_rd_addr,
    input  logic [31:0]               axi_rd_data
);

    typedef enum logic [1:0] {
        W_IDLE  = 2'd0,
        W_ISSUE = 2'd1,
        W_RESP  = 2'd2
    } w_state_e;

    typedef enum logic [1:0] {
        R_IDLE = 2'd0,
        R_WAIT = 2'd1,
        R_RESP = 2'd2
    } r_state_e;

    localparam logic [1:0] RD_LAT = 2'(RD_LATENCY);

    // The core never signals an error, so both responses are always OKAY.
    assign s_bresp = 2'b00;
    assign s_rresp = 2'b00;

    // =======================================================================
    // Write path
    // =======================================================================
    w_state_e                  w_state_q, w_state_d;
    logic                      aw_captured_q, aw_captured_d;
    logic                      w_captured_q, w_captured_d;
    logic [AXI_ADDR_WIDTH-1:0] wr_addr_q;
    logic [31:0]               wr_data_q;
    logic [3:0]                wr_strb_q;
    logic                      aw_hs, w_hs;

    assign aw_hs = s_awvalid & s_awready;
    assign w_hs  = s_wvalid  & s_wready;

    // State register
    // NOTE: sequential state uses non-blocking assignments only. Every flop
    // then samples pre-edge values, whatever order the processes run in.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            w_state_q     <= W_IDLE;
            aw_captured_q <= 1'b0;
            w_captured_q  <= 1'b0;
        end else begin
            w_state_q     <= w_state_d;
            aw_captured_q <= aw_captured_d;
            w_captured_q  <= w_captured_d;
        end
    end

    // Next-state logic. AW and W may arrive in either order or together.
    // The handshakes of the current cycle count towards "both captured".
    // NOTE: every variable gets a default before the case. A path that skips
    // the assignment would otherwise infer a latch.
    always_comb begin
        w_state_d     = w_state_q;
        aw_captured_d = aw_captured_q;
        w_captured_d  = w_captured_q;
        unique case (w_state_q)
            W_IDLE: begin
                if (aw_hs) aw_captured_d = 1'b1;
                if (w_hs)  w_captured_d  = 1'b1;
                if (aw_captured_d && w_captured_d) w_state_d = W_ISSUE;
            end
            W_ISSUE: begin
                aw_captured_d = 1'b0;
                w_captured_d  = 1'b0;
                w_state_d     = W_RESP;
            end
            W_RESP: begin
                if (s_bready) w_state_d = W_IDLE;
            end
            default: w_state_d = W_IDLE;
        endcase
    end

    // Output logic. The ready signals stay low from capture until the B handshake.
    always_comb begin
        s_awready = 1'b0;
        s_wready  = 1'b0;
        s_bvalid  = 1'b0;
        axi_wr_en = 1'b0;
        unique case (w_state_q)
            W_IDLE: begin
                s_awready = ~aw_captured_q;
                s_wready  = ~w_captured_q;
            end
            W_ISSUE: axi_wr_en = 1'b1;
            W_RESP:  s_bvalid  = 1'b1;
            default: ;
        endcase
    end

    // Write datapath. It only loads on a handshake, so the fields stay
    // stable through W_ISSUE.
    // NOTE: these datapath registers are reset on purpose. The core-side
    // buses must read 0 as soon as rst_n falls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_addr_q <= '0;
            wr_data_q <= '0;
            wr_strb_q <= '0;
        end else begin
            if (aw_hs) wr_addr_q <= s_awaddr;
            if (w_hs) begin
                wr_data_q <= s_wdata;
                wr_strb_q <= s_wstrb;
            end
        end
    end

    assign axi_wr_addr   = wr_addr_q;
    assign axi_wr_data   = wr_data_q;
    assign axi_wr_strobe = wr_strb_q;

    // =======================================================================
    // Read path
    // =======================================================================
    r_state_e                  r_state_q, r_state_d;
    logic [1:0]                lat_cnt_q, lat_cnt_d;
    logic [AXI_ADDR_WIDTH-1:0] rd_addr_q;
    logic [31:0]               rdata_q;
    logic                      ar_hs;
    logic                      rd_capture;

    assign ar_hs = s_arvalid & s_arready;

    // The core's data is valid once the counter reaches RD_LATENCY.
    // With RD_LATENCY = 0, capture happens at the end of the rd_en cycle.
    assign rd_capture = (r_state_q == R_WAIT) && (lat_cnt_q == RD_LAT);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state_q <= R_IDLE;
            lat_cnt_q <= 2'd0;
        end else begin
            r_state_q <= r_state_d;
            lat_cnt_q <= lat_cnt_d;
        end
    end

    // Next-state logic
    always_comb begin
        r_state_d = r_state_q;
        lat_cnt_d = lat_cnt_q;
        unique case (r_state_q)
            R_IDLE: begin
                if (ar_hs) begin
                    r_state_d = R_WAIT;
                    lat_cnt_d = 2'd0;
                end
            end
            R_WAIT: begin
                lat_cnt_d = lat_cnt_q + 2'd1;
                if (rd_capture) r_state_d = R_RESP;
            end
            R_RESP: begin
                if (s_rready) r_state_d = R_IDLE;
            end
            default: r_state_d = R_IDLE;
        endcase
    end

    // Output logic. rd_en is high only in the first R_WAIT cycle.
    always_comb begin
        s_arready = 1'b0;
        s_rvalid  = 1'b0;
        axi_rd_en = 1'b0;
        unique case (r_state_q)
            R_IDLE:  s_arready = 1'b1;
            R_WAIT:  axi_rd_en = (lat_cnt_q == 2'd0);
            R_RESP:  s_rvalid  = 1'b1;
            default: ;
        endcase
    end

    // Read datapath. rd_addr_q only moves on an AR handshake. The core's
    // combinational output mux therefore sees a stable address from rd_en
    // through the capture edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_addr_q <= '0;
            rdata_q   <= '0;
        end else begin
            if (ar_hs)      rd_addr_q <= s_araddr;
            if (rd_capture) rdata_q   <= axi_rd_data;
        end
    end

    assign axi_rd_addr = rd_addr_q;
    assign s_rdata     = rdata_q;

endmodule

// File: tb/tb_axi_lite_slave_adapter.sv
// ---------------------------------------------------------------------------
// tb_axi_lite_slave_adapter
//
// Directed bench for axi_lite_slave_adapter. The main instance uses
// RD_LATENCY = 1. Two more instances (RD_LATENCY = 0 and 3) share the same
// AXI inputs so read latency can be compared side by side.
//
// Each instance has a stub core: address 0x60804 returns 1 combinationally,
// and every other address returns a registered RAM word of the form
// 0xD000_0000 | address.
//
// Inputs are driven and outputs sampled on the falling edge.
// ---------------------------------------------------------------------------
module tb_axi_lite_slave_adapter;

    localparam int AW = 20;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n;
    logic [AW-1:0] s_awaddr, s_araddr;
    logic          s_awvalid, s_wvalid, s_bready, s_arvalid, s_rready;
    logic [31:0]   s_wdata;
    logic [3:0]    s_wstrb;

    // main instance (RD_LATENCY = 1)
    logic          s_awready, s_wready, s_bvalid, s_arready, s_rvalid;
    logic [1:0]    s_bresp, s_rresp;
    logic [31:0]   s_rdata;
    logic          axi_wr_en, axi_rd_en;
    logic [AW-1:0] axi_wr_addr, axi_rd_addr;
    logic [31:0]   axi_wr_data, axi_rd_data;
    logic [3:0]    axi_wr_strobe;
    logic [31:0]   ram_q;

    // RD_LATENCY = 0 instance
    logic          l0_awready, l0_wready, l0_bvalid, l0_arready, l0_rvalid;
    logic [1:0]    l0_bresp, l0_rresp;
    logic [31:0]   l0_rdata;
    logic          l0_wr_en, l0_rd_en;
    logic [AW-1:0] l0_wr_addr, l0_rd_addr;
    logic [31:0]   l0_wr_data, l0_rd_data;
    logic [3:0]    l0_wr_strobe;
    logic [31:0]   l0_ram_q;

    // RD_LATENCY = 3 instance
    logic          l3_awready, l3_wready, l3_bvalid, l3_arready, l3_rvalid;
    logic [1:0]    l3_bresp, l3_rresp;
    logic [31:0]   l3_rdata;
    logic          l3_wr_en, l3_rd_en;
    logic [AW-1:0] l3_wr_addr, l3_rd_addr;
    logic [31:0]   l3_wr_data, l3_rd_data;
    logic [3:0]    l3_wr_strobe;
    logic [31:0]   l3_ram_q;

    // Stub cores
    always @(posedge clk) ram_q    <= 32'hD000_0000 | {12'h000, axi_rd_addr};
    always @(posedge clk) l0_ram_q <= 32'hD000_0000 | {12'h000, l0_rd_addr};
    always @(posedge clk) l3_ram_q <= 32'hD000_0000 | {12'h000, l3_rd_addr};
    assign axi_rd_data = (axi_rd_addr == 20'h60804) ? 32'h1 : ram_q;
    assign l0_rd_data  = (l0_rd_addr  == 20'h60804) ? 32'h1 : l0_ram_q;
    assign l3_rd_data  = (l3_rd_addr  == 20'h60804) ? 32'h1 : l3_ram_q;

    // Pulse counters for the main instance
    int wr_en_cnt = 0;
    int rd_en_cnt = 0;
    always @(posedge clk) begin
        if (axi_wr_en) wr_en_cnt <= wr_en_cnt + 1;
        if (axi_rd_en) rd_en_cnt <= rd_en_cnt + 1;
    end

    axi_lite_slave_adapter #(.AXI_ADDR_WIDTH(AW), .RD_LATENCY(1)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .s_awaddr(s_awaddr), .s_awvalid(s_awvalid), .s_awready(s_awready),
        .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wvalid(s_wvalid), .s_wready(s_wready),
        .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
        .s_araddr(s_araddr), .s_arvalid(s_arvalid), .s_arready(s_arready),
        .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid), .s_rready(s_rready),
        .axi_wr_en(axi_wr_en), .axi_wr_addr(axi_wr_addr), .axi_wr_data(axi_wr_data),
        .axi_wr_strobe(axi_wr_strobe), .axi_rd_en(axi_rd_en), .axi_rd_addr(axi_rd_addr),
        .axi_rd_data(axi_rd_data)
    );

    axi_lite_slave_adapter #(.AXI_ADDR_WIDTH(AW), .RD_LATENCY(0)) u_lat0 (
        .clk(clk), .rst_n(rst_n),
        .s_awaddr(s_awaddr), .s_awvalid(s_awvalid), .s_awready(l0_awready),
        .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wvalid(s_wvalid), .s_wready(l0_wready),
        .s_bresp(l0_bresp), .s_bvalid(l0_bvalid), .s_bready(s_bready),
        .s_araddr(s_araddr), .s_arvalid(s_arvalid), .s_arready(l0_arready),
        .s_rdata(l0_rdata), .s_rresp(l0_rresp), .s_rvalid(l0_rvalid), .s_rready(s_rready),
        .axi_wr_en(l0_wr_en), .axi_wr_addr(l0_wr_addr), .axi_wr_data(l0_wr_data),
        .axi_wr_strobe(l0_wr_strobe), .axi_rd_en(l0_rd_en), .axi_rd_addr(l0_rd_addr),
        .axi_rd_data(l0_rd_data)
    );

    axi_lite_slave_adapter #(.AXI_ADDR_WIDTH(AW), .RD_LATENCY(3)) u_lat3 (
        .clk(clk), .rst_n(rst_n),
        .s_awaddr(s_awaddr), .s_awvalid(s_awvalid), .s_awready(l3_awready),
        .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wvalid(s_wvalid), .s_wready(l3_wready),
        .s_bresp(l3_bresp), .s_bvalid(l3_bvalid), .s_bready(s_bready),
        .s_araddr(s_araddr), .s_arvalid(s_arvalid), .s_arready(l3_arready),
        .s_rdata(l3_rdata), .s_rresp(l3_rresp), .s_rvalid(l3_rvalid), .s_rready(s_rready),
        .axi_wr_en(l3_wr_en), .axi_wr_addr(l3_wr_addr), .axi_wr_data(l3_wr_data),
        .axi_wr_strobe(l3_wr_strobe), .axi_rd_en(l3_rd_en), .axi_rd_addr(l3_rd_addr),
        .axi_rd_data(l3_rd_data)
    );

    int checks_total  = 0;
    int checks_passed = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks_total++;
        assert (obs === exp) begin
            checks_passed++;
        end else begin
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    initial begin
        int   base_wr, base_rd;
        int   first0, first1, first3;
        logic [31:0] d0, d1, d3;
        logic seen;

        rst_n     = 1'b0;
        s_awaddr  = '0; s_awvalid = 1'b0;
        s_wdata   = '0; s_wstrb   = '0; s_wvalid = 1'b0;
        s_bready  = 1'b0;
        s_araddr  = '0; s_arvalid = 1'b0;
        s_rready  = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        tick();

        // ---------------- reset state ----------------
        check("rst_ready", {s_awready, s_wready, s_arready}, 3'b111);
        check("rst_valid", {s_bvalid, s_rvalid, axi_wr_en, axi_rd_en}, 4'b0000);
        check("rst_resp", {s_bresp, s_rresp}, 4'b0000);
        check("rst_regs", {axi_wr_addr, axi_wr_strobe, axi_rd_addr}, 44'h0);
        check("rst_data", {axi_wr_data, s_rdata}, 64'h0);
        check("rst_lat0", {l0_awready, l0_wready, l0_arready, l0_bvalid, l0_rvalid, l0_bresp, l0_rresp}, 9'h1C0);
        check("rst_lat3", {l3_awready, l3_wready, l3_arready, l3_bvalid, l3_rvalid, l3_bresp, l3_rresp}, 9'h1C0);

        // ---------------- T1: AW first, W three cycles later ----------------
        base_wr   = wr_en_cnt;
        s_awaddr  = 20'h60808;
        s_awvalid = 1'b1;
        tick();
        s_awvalid = 1'b0;
        check("t1_awready_after_aw", s_awready, 1'b0);
        check("t1_wready_after_aw", s_wready, 1'b1);
        check("t1_no_wr_en_yet", axi_wr_en, 1'b0);
        tick();
        tick();
        s_wdata  = 32'h1;
        s_wstrb  = 4'hF;
        s_wvalid = 1'b1;
        tick();
        s_wvalid = 1'b0;
        check("t1_wr_en", axi_wr_en, 1'b1);
        check("t1_wr_addr", axi_wr_addr, 20'h60808);
        check("t1_wr_data", axi_wr_data, 32'h1);
        check("t1_wr_strb", axi_wr_strobe, 4'hF);
        check("t1_ready_issue", {s_awready, s_wready, s_bvalid}, 3'b000);
        check("t1_lat0_wr", {l0_wr_en, l0_wr_addr, l0_wr_data, l0_wr_strobe}, {1'b1, 20'h60808, 32'h1, 4'hF});
        check("t1_lat3_wr", {l3_wr_en, l3_wr_addr, l3_wr_data, l3_wr_strobe}, {1'b1, 20'h60808, 32'h1, 4'hF});
        tick();
        check("t1_wr_en_drop", axi_wr_en, 1'b0);
        check("t1_bvalid", s_bvalid, 1'b1);
        check("t1_bresp", s_bresp, 2'b00);
        check("t1_ready_resp", {s_awready, s_wready}, 2'b00);
        s_bready = 1'b1;
        tick();
        s_bready = 1'b0;
        check("t1_bvalid_done", s_bvalid, 1'b0);
        check("t1_ready_back", {s_awready, s_wready}, 2'b11);
        check("t1_one_pulse", wr_en_cnt - base_wr, 1);

        // ---------------- T2a: AW and W in the same cycle ----------------
        base_wr   = wr_en_cnt;
        s_awaddr  = 20'h60810;
        s_wdata   = 32'hA5A5_0001;
        s_wstrb   = 4'hC;
        s_awvalid = 1'b1;
        s_wvalid  = 1'b1;
        tick();
        s_awvalid = 1'b0;
        s_wvalid  = 1'b0;
        check("t2a_wr_en", axi_wr_en, 1'b1);
        check("t2a_fields", {axi_wr_addr, axi_wr_data, axi_wr_strobe}, {20'h60810, 32'hA5A5_0001, 4'hC});
        s_bready = 1'b1;
        tick();
        check("t2a_bvalid", s_bvalid, 1'b1);
        check("t2a_ready_resp", {s_awready, s_wready}, 2'b00);
        tick();
        check("t2a_bvalid_done", s_bvalid, 1'b0);
        s_bready = 1'b0;

        // ---------------- T2b: W two cycles before AW ----------------
        s_wdata  = 32'h0000_1234;
        s_wstrb  = 4'h3;
        s_wvalid = 1'b1;
        tick();
        s_wvalid = 1'b0;
        check("t2b_wready_after_w", s_wready, 1'b0);
        check("t2b_awready_after_w", s_awready, 1'b1);
        check("t2b_no_wr_en_yet", axi_wr_en, 1'b0);
        tick();
        s_awaddr  = 20'h6080C;
        s_awvalid = 1'b1;
        tick();
        s_awvalid = 1'b0;
        check("t2b_wr_en", axi_wr_en, 1'b1);
        check("t2b_fields", {axi_wr_addr, axi_wr_data, axi_wr_strobe}, {20'h6080C, 32'h0000_1234, 4'h3});
        s_bready = 1'b1;
        tick();
        check("t2b_bvalid", s_bvalid, 1'b1);
        tick();
        check("t2b_bvalid_done", s_bvalid, 1'b0);
        s_bready = 1'b0;
        check("t2_two_pulses", wr_en_cnt - base_wr, 2);

        // ---------------- T3: read latency 1 / 0 / 3 ----------------
        base_rd   = rd_en_cnt;
        s_araddr  = 20'h60804;
        s_arvalid = 1'b1;
        s_rready  = 1'b1;
        tick();
        s_arvalid = 1'b0;
        check("t3_rd_en", {axi_rd_en, l0_rd_en, l3_rd_en}, 3'b111);
        check("t3_rd_addr", axi_rd_addr, 20'h60804);
        check("t3_arready_low", s_arready, 1'b0);
        check("t3_no_rvalid_yet", s_rvalid, 1'b0);
        first0 = 0; first1 = 0; first3 = 0;
        d0 = '0; d1 = '0; d3 = '0;
        for (int k = 1; k <= 6; k++) begin
            tick();
            if (s_rvalid && first1 == 0) begin first1 = k; d1 = s_rdata; end
            if (l0_rvalid && first0 == 0) begin first0 = k; d0 = l0_rdata; end
            if (l3_rvalid && first3 == 0) begin first3 = k; d3 = l3_rdata; end
            if (k == 1) begin
                check("t3_rd_en_single", axi_rd_en, 1'b0);
                check("t3_rd_addr_stable", axi_rd_addr, 20'h60804);
            end
            if (k == 3) check("t3_lat3_addr_stable", {l3_rd_en, l3_rd_addr}, {1'b0, 20'h60804});
        end
        check("t3_lat1_edges", first1, 2);
        check("t3_lat0_edges", first0, 1);
        check("t3_lat3_edges", first3, 4);
        check("t3_lat1_data", d1, 32'h1);
        check("t3_lat0_data", d0, 32'h1);
        check("t3_lat3_data", d3, 32'h1);
        check("t3_rresp", {s_rresp, l0_rresp, l3_rresp}, 6'b0);
        check("t3_one_rd_pulse", rd_en_cnt - base_rd, 1);

        // ---------------- T3b: RAM-backed read ----------------
        s_araddr  = 20'h00010;
        s_arvalid = 1'b1;
        tick();
        s_arvalid = 1'b0;
        tick();
        check("t3b_rvalid_early", s_rvalid, 1'b0);
        tick();
        check("t3b_rvalid", s_rvalid, 1'b1);
        check("t3b_rdata", s_rdata, 32'hD000_0010);
        repeat (4) tick();
        s_rready = 1'b0;

        // ---------------- T4: B and R back-pressure ----------------
        base_wr   = wr_en_cnt;
        base_rd   = rd_en_cnt;
        s_awaddr  = 20'h60814;
        s_wdata   = 32'hCAFE_F00D;
        s_wstrb   = 4'hF;
        s_araddr  = 20'h00020;
        s_awvalid = 1'b1;
        s_wvalid  = 1'b1;
        s_arvalid = 1'b1;
        tick();
        // Keep offering new requests with different fields. None may be taken.
        s_awaddr = 20'h7FFFF;
        s_araddr = 20'h7FFFF;
        s_wdata  = 32'hDEAD_BEEF;
        tick();
        tick();
        for (int i = 0; i < 10; i++) begin
            tick();
            check("t4_bvalid_hold", s_bvalid, 1'b1);
            check("t4_rvalid_hold", s_rvalid, 1'b1);
            check("t4_rdata_hold", s_rdata, 32'hD000_0020);
            check("t4_no_accept", {s_awready, s_wready, s_arready}, 3'b000);
        end
        s_awvalid = 1'b0;
        s_wvalid  = 1'b0;
        s_arvalid = 1'b0;
        check("t4_wr_fields_kept", {axi_wr_addr, axi_wr_data}, {20'h60814, 32'hCAFE_F00D});
        check("t4_rd_addr_kept", axi_rd_addr, 20'h00020);
        check("t4_one_wr_pulse", wr_en_cnt - base_wr, 1);
        check("t4_one_rd_pulse", rd_en_cnt - base_rd, 1);
        s_bready = 1'b1;
        s_rready = 1'b1;
        tick();
        check("t4_released", {s_bvalid, s_rvalid}, 2'b00);
        check("t4_ready_back", {s_awready, s_wready, s_arready}, 3'b111);

        // ---------------- T5: simultaneous write and read ----------------
        s_awaddr  = 20'h60000;
        s_araddr  = 20'h60000;
        s_wdata   = 32'h0000_BEEF;
        s_wstrb   = 4'hF;
        s_awvalid = 1'b1;
        s_wvalid  = 1'b1;
        s_arvalid = 1'b1;
        tick();
        s_awvalid = 1'b0;
        s_wvalid  = 1'b0;
        s_arvalid = 1'b0;
        check("t5_both_en", {axi_wr_en, axi_rd_en}, 2'b11);
        check("t5_addrs", {axi_wr_addr, axi_rd_addr}, {20'h60000, 20'h60000});
        tick();
        check("t5_b_first", {s_bvalid, s_rvalid}, 2'b10);
        tick();
        check("t5_r_second", {s_bvalid, s_rvalid}, 2'b01);
        check("t5_rdata", s_rdata, 32'hD006_0000);
        tick();
        check("t5_done", {s_bvalid, s_rvalid}, 2'b00);
        repeat (3) tick();

        // ---------------- T6: reset during W_ISSUE ----------------
        s_awaddr  = 20'h60818;
        s_wdata   = 32'h0000_5555;
        s_wstrb   = 4'h1;
        s_awvalid = 1'b1;
        s_wvalid  = 1'b1;
        tick();
        s_awvalid = 1'b0;
        s_wvalid  = 1'b0;
        check("t6_wr_en_before_rst", axi_wr_en, 1'b1);
        #1 rst_n = 1'b0;
        #1;
        check("t6_async_wr", {axi_wr_en, axi_wr_addr, axi_wr_strobe, s_bvalid}, 26'h0);
        check("t6_async_wr_data", axi_wr_data, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            seen = seen | s_bvalid | axi_wr_en;
        end
        check("t6_no_bvalid_after_rst", seen, 1'b0);

        // ---------------- T6b: reset during R_WAIT ----------------
        s_araddr  = 20'h60804;
        s_arvalid = 1'b1;
        tick();
        s_arvalid = 1'b0;
        check("t6b_rd_en_before_rst", axi_rd_en, 1'b1);
        #1 rst_n = 1'b0;
        #1;
        check("t6b_async_rd", {axi_rd_en, axi_rd_addr, s_rvalid, l3_rd_addr}, 42'h0);
        check("t6b_async_rdata", s_rdata, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            seen = seen | s_rvalid | l0_rvalid | l3_rvalid;
        end
        check("t6b_no_rvalid_after_rst", seen, 1'b0);

        // ---------------- T6c: normal write after reset ----------------
        s_awaddr  = 20'h6081C;
        s_wdata   = 32'h0BAD_F00D;
        s_wstrb   = 4'hF;
        s_awvalid = 1'b1;
        s_wvalid  = 1'b1;
        tick();
        s_awvalid = 1'b0;
        s_wvalid  = 1'b0;
        check("t6c_wr", {axi_wr_en, axi_wr_addr, axi_wr_data, axi_wr_strobe}, {1'b1, 20'h6081C, 32'h0BAD_F00D, 4'hF});
        tick();
        check("t6c_bvalid", {s_bvalid, s_bresp}, 3'b100);
        tick();
        check("t6c_bvalid_done", s_bvalid, 1'b0);

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
